alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Return path of the ALU datapath. Accepts ALU results, updates the condition flags, and writes results back to the register file in order.
- Sits between the ALU output and the register-file write port. The write port is shared with the load path and arbitrated by rf_grant.
- Holds up to two pending results.
- Exposes the youngest pending destination/value as a bypass so the operand decoder can forward data not yet written.

Parameters:
- DATA_W, 16, datapath width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- res_valid  input  1  ALU presents a result this cycle.
- res_ready  output  1  block can accept a result this cycle.
- res_data  input  DATA_W  ALU result.
- res_carry  input  1  ALU carry-out.
- res_ovf  input  1  ALU signed overflow.
- res_rd  input  ADDR_W  destination register.
- res_wr_en  input  1  result must be written to res_rd (0 = flags-only op, e.g. compare).
- res_flag_en  input  1  result updates flags.
- rf_grant  input  1  register-file write port available to this block this cycle.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  ADDR_W  write address.
- rf_wdata  output  DATA_W  write data.
- flags  output  4  {Z,N,C,V}.
- fwd_valid  output  1  a pending entry will write a register.
- fwd_rd  output  ADDR_W  destination of youngest pending writing entry.
- fwd_data  output  DATA_W  data of youngest pending writing entry.
- busy  output  1  any entry pending.

Behaviour:
- Storage
  - 2-entry in-order FIFO. Each entry holds {data, rd, wr_en}.
  - State machine on occupancy: EMPTY, ONE, FULL.
- Accept
  - Accept occurs when res_valid && res_ready.
  - res_ready = !rst && state!=FULL, combinational.
  - res_ready does not depend on rf_grant. There is no same-cycle push-through when FULL.
- Flags
  - Updated on the accept edge when res_flag_en=1:
    - Z = (res_data==0)
    - N = res_data[DATA_W-1]
    - C = res_carry
    - V = res_ovf
  - New flags are visible the cycle after accept.
  - flags hold otherwise.
  - Flags are updated at accept, not at writeback, so they reflect ALU program order.
- Head processing (combinational from the FIFO head)
  - Head with wr_en=1:
    - rf_we = rf_grant.
    - rf_waddr/rf_wdata = head rd/data.
    - Pop when rf_we=1.
  - Head with wr_en=0: pop unconditionally in one cycle, rf_we=0.
  - Empty: rf_we=0; rf_waddr/rf_wdata = 0.
- Latency
  - Result accepted at edge N appears on rf_we in cycle N+1 if rf_grant is high, and is written at edge N+1.
  - Each cycle rf_grant is low adds one cycle.
- Throughput
  - Simultaneous push and pop in state ONE stays ONE.
  - With rf_grant held high, the block sustains one result per cycle.
- State transitions
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - FULL→ONE on pop; a push is impossible in FULL.
- Ordering
  - Writes issue strictly in acceptance order.
  - Two entries with the same rd are both written, older first.
- Forwarding
  - fwd_valid=1 if any pending entry has wr_en=1.
  - fwd_rd/fwd_data come from the youngest such entry; otherwise they are 0.
  - An entry popped this cycle still drives fwd this cycle.
- busy = (state!=EMPTY).
- Reset (async, immediate)
  - FIFO cleared, state EMPTY.
  - flags=4'b0000, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_rd=0, fwd_data=0, busy=0, res_ready=0.
  - Reset mid-operation discards pending results with no partial write.
  - First accept is possible in the first cycle after rst deasserts.
- Width rules
  - No arithmetic on data; values pass through unmodified.
  - Z uses the full DATA_W compare.

Test Plan:
- Reset then res_valid=1, res_data=16'h0000, res_rd=3, wr_en=1, flag_en=1, carry=1, rf_grant=1:
  - next cycle flags=4'b1010, rf_we=1, rf_waddr=3, rf_wdata=0.
  - following cycle busy=0.
- rf_grant=0, push 16'h8001 (rd=1) then 16'h0005 (rd=2):
  - res_ready=0 after second accept.
  - fwd_rd=2, fwd_data=16'h0005.
  - raise rf_grant: writes rd1=8001 then rd2=0005 on consecutive cycles, res_ready returns to 1 after the first write.
- Compare op wr_en=0, flag_en=1, data=16'hFFFF, ovf=1, rf_grant=0:
  - flags=4'b0101 next cycle.
  - no rf_we at any time.
  - entry pops in one cycle, busy=0 after.
- Back-to-back 4 results, rf_grant=1, res_valid held:
  - res_ready stays 1, one rf_we per cycle in order, occupancy never exceeds ONE.
- Two pending writes to rd=4, values 16'h1111 then 16'h2222:
  - fwd_data=16'h2222.
  - rf writes 1111 then 2222.
- Assert rst while FULL and rf_grant=0:
  - all outputs 0 immediately (asynchronous).
  - after release and rf_grant=1, no rf_we until a new accept.

Source files
------------

// File: rtl/alu_writeback_if.sv
// ALU result / register-file write-port bundle for alu_writeback.
// master = ALU and register-file side, slave = the writeback block.
interface alu_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_ovf;
  logic [ADDR_W-1:0] res_rd;
  logic              res_wr_en;
  logic              res_flag_en;
  logic              rf_grant;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        flags;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              busy;

  modport master (
    output res_valid, res_data, res_carry, res_ovf, res_rd, res_wr_en,
           res_flag_en, rf_grant,
    input  res_ready, rf_we, rf_waddr, rf_wdata, flags, fwd_valid, fwd_rd,
           fwd_data, busy
  );

  modport slave (
    input  res_valid, res_data, res_carry, res_ovf, res_rd, res_wr_en,
           res_flag_en, rf_grant,
    output res_ready, rf_we, rf_waddr, rf_wdata, flags, fwd_valid, fwd_rd,
           fwd_data, busy
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry in-order result FIFO feeding the shared
// register-file write port, flag register updated at accept, youngest-entry bypass.
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic           clk,
  input logic           rst,
  alu_writeback_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data0, data1;
  logic [ADDR_W-1:0] rd0, rd1;
  logic              wr0, wr1;
  logic [3:0]        flags_q;
  logic              ready, push, pop;

  assign ready = !rst && (state != FULL);
  assign push  = bus.res_valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Slot 0 is always the head; slot 1 only holds the younger entry when FULL.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (state != EMPTY) begin
      if (wr0) begin
        bus.rf_we    = bus.rf_grant;
        bus.rf_waddr = rd0;
        bus.rf_wdata = data0;
        pop          = bus.rf_grant;
      end else begin
        pop = 1'b1;
      end
    end
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (!push && pop) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = '0;
    bus.fwd_data  = '0;
    if (state == FULL && wr1) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_rd    = rd1;
      bus.fwd_data  = data1;
    end else if (state != EMPTY && wr0) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_rd    = rd0;
      bus.fwd_data  = data0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0 <= '0;
      data1 <= '0;
      rd0   <= '0;
      rd1   <= '0;
      wr0   <= 1'b0;
      wr1   <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          data0 <= bus.res_data;
          rd0   <= bus.res_rd;
          wr0   <= bus.res_wr_en;
        end
        ONE: begin
          if (push && pop) begin
            data0 <= bus.res_data;
            rd0   <= bus.res_rd;
            wr0   <= bus.res_wr_en;
          end else if (push) begin
            data1 <= bus.res_data;
            rd1   <= bus.res_rd;
            wr1   <= bus.res_wr_en;
          end
        end
        FULL: if (pop) begin
          data0 <= data1;
          rd0   <= rd1;
          wr0   <= wr1;
        end
        default: ;
      endcase
    end
  end

  // Flags track ALU program order, so they change at accept rather than at writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else if (push && bus.res_flag_en)
      flags_q <= {bus.res_data == '0, bus.res_data[DATA_W-1], bus.res_carry, bus.res_ovf};
  end

  assign bus.res_ready = ready;
  assign bus.flags     = flags_q;
  assign bus.busy      = (state != EMPTY);

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: vector table, directed sequences,
// and a negedge reference model of the pending-result queue.
module tb_alu_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_writeback_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  alu_writeback #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic        ovf;
    logic [2:0]  rd;
    logic        wr;
    logic        fe;
    logic        grant;
    logic [3:0]  exp_flags;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        wr;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   max_occ  = 0;
  ent_t q[$];
  logic [3:0] exp_flags = 4'b0000;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare outputs against pending queue, then apply the edge.
  logic        m_fv, m_ready, m_we, m_pop;
  logic [2:0]  m_frd;
  logic [15:0] m_fd;
  ent_t        m_new;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_flags = 4'b0000;
      chk("rst_ready", {31'd0, bus.res_ready}, 0);
      chk("rst_we", {31'd0, bus.rf_we}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_flags", {28'd0, bus.flags}, 0);
    end else begin
      m_fv = 1'b0; m_frd = '0; m_fd = '0;
      for (int i = 0; i < q.size(); i++)
        if (q[i].wr) begin m_fv = 1'b1; m_frd = q[i].rd; m_fd = q[i].data; end
      m_ready = (q.size() < 2);
      m_we    = (q.size() > 0) && q[0].wr && bus.rf_grant;
      m_pop   = (q.size() > 0) && (!q[0].wr || bus.rf_grant);
      chk("m_busy", {31'd0, bus.busy}, {31'd0, q.size() != 0});
      chk("m_ready", {31'd0, bus.res_ready}, {31'd0, m_ready});
      chk("m_flags", {28'd0, bus.flags}, {28'd0, exp_flags});
      chk("m_fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, m_fv});
      chk("m_fwd_rd", {29'd0, bus.fwd_rd}, {29'd0, m_frd});
      chk("m_fwd_data", {16'd0, bus.fwd_data}, {16'd0, m_fd});
      chk("m_rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
      if (m_we) begin
        chk("m_waddr", {29'd0, bus.rf_waddr}, {29'd0, q[0].rd});
        chk("m_wdata", {16'd0, bus.rf_wdata}, {16'd0, q[0].data});
      end else if (q.size() == 0) begin
        chk("m_waddr_idle", {29'd0, bus.rf_waddr}, 0);
        chk("m_wdata_idle", {16'd0, bus.rf_wdata}, 0);
      end
      if (m_pop) void'(q.pop_front());
      if (bus.res_valid && m_ready) begin
        m_new.data = bus.res_data;
        m_new.rd   = bus.res_rd;
        m_new.wr   = bus.res_wr_en;
        q.push_back(m_new);
        if (bus.res_flag_en)
          exp_flags = {bus.res_data == 16'h0000, bus.res_data[15], bus.res_carry, bus.res_ovf};
      end
      if (q.size() > max_occ) max_occ = q.size();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic c, input logic o,
                       input logic [2:0] rd, input logic wr, input logic fe);
    bus.res_valid   = v;
    bus.res_data    = d;
    bus.res_carry   = c;
    bus.res_ovf     = o;
    bus.res_rd      = rd;
    bus.res_wr_en   = wr;
    bus.res_flag_en = fe;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.busy; i++) cyc();
    chk("idle", {31'd0, bus.busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 4'b1010, 1'b1};
    vecs[1] = '{16'hFFFF, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0};
    vecs[2] = '{16'h8001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1};
    vecs[3] = '{16'h1234, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1};
    vecs[4] = '{16'h0001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0};
    vecs[5] = '{16'h7FFF, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0};
    vecs[6] = '{16'h0000, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 4'b1001, 1'b1};

    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    bus.rf_grant = 1'b0;
    #1;
    chk("reset_ready", {31'd0, bus.res_ready}, 0);
    chk("reset_fwd_valid", {31'd0, bus.fwd_valid}, 0);
    chk("reset_waddr", {29'd0, bus.rf_waddr}, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, bus.res_ready}, 1);

    // Single-result vectors from idle
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].data, vecs[k].carry, vecs[k].ovf, vecs[k].rd, vecs[k].wr, vecs[k].fe);
      bus.rf_grant = vecs[k].grant;
      cyc();
      bus.res_valid = 1'b0;
      chk("vec_flags", {28'd0, bus.flags}, {28'd0, vecs[k].exp_flags});
      chk("vec_we", {31'd0, bus.rf_we}, {31'd0, vecs[k].exp_we});
      if (vecs[k].exp_we) begin
        chk("vec_waddr", {29'd0, bus.rf_waddr}, {29'd0, vecs[k].rd});
        chk("vec_wdata", {16'd0, bus.rf_wdata}, {16'd0, vecs[k].data});
      end
      bus.rf_grant = 1'b1;
      cyc();
      chk("vec_busy_after", {31'd0, bus.busy}, 0);
      wait_idle();
    end

    // Fill with grant low, then drain in order
    bus.rf_grant = 1'b0;
    drive(1'b1, 16'h8001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 16'h0005, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
    chk("fill_ready_one", {31'd0, bus.res_ready}, 1);
    cyc();
    bus.res_valid = 1'b0;
    chk("full_ready", {31'd0, bus.res_ready}, 0);
    chk("full_fwd_rd", {29'd0, bus.fwd_rd}, 2);
    chk("full_fwd_data", {16'd0, bus.fwd_data}, 16'h0005);
    cyc();
    bus.rf_grant = 1'b1;
    #1;
    chk("drain1_we", {31'd0, bus.rf_we}, 1);
    chk("drain1_waddr", {29'd0, bus.rf_waddr}, 1);
    chk("drain1_wdata", {16'd0, bus.rf_wdata}, 16'h8001);
    cyc();
    chk("drain2_ready", {31'd0, bus.res_ready}, 1);
    chk("drain2_we", {31'd0, bus.rf_we}, 1);
    chk("drain2_waddr", {29'd0, bus.rf_waddr}, 2);
    chk("drain2_wdata", {16'd0, bus.rf_wdata}, 16'h0005);
    cyc();
    chk("drain_busy", {31'd0, bus.busy}, 0);

    // Back-to-back with grant held: one write per cycle, never more than one pending
    max_occ = 0;
    bus.rf_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0, 3'(k), 1'b1, 1'b0);
      chk("b2b_ready", {31'd0, bus.res_ready}, 1);
      cyc();
    end
    bus.res_valid = 1'b0;
    wait_idle();
    chk("b2b_max_occ", max_occ, 1);

    // Same destination twice: bypass shows the younger, writes go older first
    bus.rf_grant = 1'b0;
    drive(1'b1, 16'h1111, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    cyc();
    drive(1'b1, 16'h2222, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
    cyc();
    bus.res_valid = 1'b0;
    chk("same_rd_fwd_rd", {29'd0, bus.fwd_rd}, 4);
    chk("same_rd_fwd_data", {16'd0, bus.fwd_data}, 16'h2222);
    bus.rf_grant = 1'b1;
    #1;
    chk("same_rd_first", {16'd0, bus.rf_wdata}, 16'h1111);
    cyc();
    chk("same_rd_second", {16'd0, bus.rf_wdata}, 16'h2222);
    wait_idle();

    // Asynchronous reset while FULL discards everything
    bus.rf_grant = 1'b0;
    drive(1'b1, 16'h0008, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 16'h0009, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1);
    cyc();
    bus.res_valid = 1'b0;
    chk("pre_rst_full", {31'd0, bus.res_ready}, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, bus.res_ready}, 0);
    chk("arst_we", {31'd0, bus.rf_we}, 0);
    chk("arst_waddr", {29'd0, bus.rf_waddr}, 0);
    chk("arst_wdata", {16'd0, bus.rf_wdata}, 0);
    chk("arst_flags", {28'd0, bus.flags}, 0);
    chk("arst_fwd_valid", {31'd0, bus.fwd_valid}, 0);
    chk("arst_fwd_rd", {29'd0, bus.fwd_rd}, 0);
    chk("arst_fwd_data", {16'd0, bus.fwd_data}, 0);
    chk("arst_busy", {31'd0, bus.busy}, 0);
    bus.rf_grant = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, bus.res_ready}, 1);
    chk("rel_we", {31'd0, bus.rf_we}, 0);
    cyc();
    chk("rel_we_later", {31'd0, bus.rf_we}, 0);
    drive(1'b1, 16'h4321, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1);
    cyc();
    bus.res_valid = 1'b0;
    chk("rel_new_we", {31'd0, bus.rf_we}, 1);
    chk("rel_new_waddr", {29'd0, bus.rf_waddr}, 5);
    chk("rel_new_wdata", {16'd0, bus.rf_wdata}, 16'h4321);
    wait_idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
